// File: rtl/tff_seq_pkg.sv
// Shared op codes and sequencer state encoding for the T flip-flop bank sequencer.
package tff_seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;
    localparam logic [1:0] OP_DN    = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_STEP   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles when t is high, synchronous active-high reset to 0.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_bank_sequencer.sv
// Command sequencer driving a bank of WIDTH T flip-flops as a loadable up/down counter.
// Optional build macro TFF_SATURATE_EN: counting stops at the limits instead of wrapping.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready; cmd_ready is
// high only in IDLE (and never while rst is high), cmd_* are sampled only on that edge, and
// cmd_valid at any other time is ignored rather than queued.
module tff_bank_sequencer
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrapped
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             wrapped_q, wrapped_d;

    logic [WIDTH-1:0] t_raw;
    logic [WIDTH-1:0] up_t, dn_t;
    logic             up_run, dn_run;
    logic             at_limit;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;

    always_comb begin
        // Running prefix AND / NOR; after the loop they flag all-ones and zero.
        up_run = 1'b1;
        dn_run = 1'b1;
        up_t   = '0;
        dn_t   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = up_run;
            dn_t[i] = dn_run;
            up_run  = up_run & q[i];
            dn_run  = dn_run & ~q[i];
        end
        at_limit = (op_q == OP_UP) ? up_run : dn_run;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        target_d  = target_q;
        rem_d     = rem_q;
        wrapped_d = 1'b0;
        t_raw     = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d     = cmd_op;
                    target_d = (cmd_op == OP_LOAD) ? cmd_data : '0;
                    rem_d    = cmd_len;
                    if (cmd_op == OP_CLEAR || cmd_op == OP_LOAD) begin
                        state_d = ST_APPLY;
                    end else if (cmd_len == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_APPLY: begin
                t_raw   = q ^ target_q;
                state_d = ST_FINISH;
            end
            ST_STEP: begin
                t_raw = (op_q == OP_UP) ? up_t : dn_t;
`ifdef TFF_SATURATE_EN
                if (at_limit) begin
                    t_raw = '0;
                end
`endif
                wrapped_d = at_limit;
                rem_d     = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_CLEAR;
            target_q  <= '0;
            rem_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            target_q  <= target_d;
            rem_q     <= rem_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign t_vec   = rst ? '0 : t_raw;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FINISH) && !rst;
    assign wrapped = wrapped_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed bench for tff_bank_sequencer (WIDTH=4, LEN_W=8) with hand-computed expectations.
module tb_tff_bank_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_len;
    logic [3:0] t_vec;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       wrapped;

    int tests_run = 0;
    int tests_failed = 0;

    tff_bank_sequencer #(
        .WIDTH (4),
        .LEN_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .t_vec     (t_vec),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'h0;
        cmd_len   = 8'd0;

        // Reset state
        tick();
        tick();
        check("rst_q", 8'(q), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_done", 8'(done), 8'h0);
        check("rst_wrapped", 8'(wrapped), 8'h0);
        check("rst_tvec", 8'(t_vec), 8'h0);
        check("rst_ready_low", 8'(cmd_ready), 8'h0);
        rst = 1'b0;
        #1;
        check("rst_ready_after", 8'(cmd_ready), 8'h1);

        // 1: reset in the middle of COUNT_UP len=10
        send(2'b10, 4'h0, 8'd10);
        tick();
        cmd_valid = 1'b0;
        check("t1_busy", 8'(busy), 8'h1);
        check("t1_tvec_step", 8'(t_vec), 8'h1);
        tick();
        tick();
        tick();
        check("t1_q_3steps", 8'(q), 8'h3);
        rst = 1'b1;
        tick();
        check("t1_q_after_rst", 8'(q), 8'h0);
        check("t1_busy_after_rst", 8'(busy), 8'h0);
        check("t1_done_after_rst", 8'(done), 8'h0);
        rst = 1'b0;
        #1;
        check("t1_ready_after_rst", 8'(cmd_ready), 8'h1);

        // 2: LOAD 1010 from 0
        send(2'b01, 4'hA, 8'd0);
        tick();
        cmd_valid = 1'b0;
        check("t2_tvec_apply", 8'(t_vec), 8'hA);
        check("t2_busy", 8'(busy), 8'h1);
        check("t2_ready_busy", 8'(cmd_ready), 8'h0);
        check("t2_done_early", 8'(done), 8'h0);
        tick();
        check("t2_q", 8'(q), 8'hA);
        check("t2_done", 8'(done), 8'h1);
        check("t2_tvec_finish", 8'(t_vec), 8'h0);
        tick();
        check("t2_done_clear", 8'(done), 8'h0);
        check("t2_ready_back", 8'(cmd_ready), 8'h1);

        // 3: LOAD E then COUNT_UP len=3
        send(2'b01, 4'hE, 8'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t3_q_load", 8'(q), 8'hE);
        tick();
        send(2'b10, 4'h0, 8'd3);
        tick();
        cmd_valid = 1'b0;
        check("t3_q_s0", 8'(q), 8'hE);
        tick();
        check("t3_q_s1", 8'(q), 8'hF);
        check("t3_wrap_s1", 8'(wrapped), 8'h0);
        tick();
`ifdef TFF_SATURATE_EN
        check("t3_q_s2", 8'(q), 8'hF);
`else
        check("t3_q_s2", 8'(q), 8'h0);
`endif
        check("t3_wrap_s2", 8'(wrapped), 8'h1);
        check("t3_done_early", 8'(done), 8'h0);
        tick();
`ifdef TFF_SATURATE_EN
        check("t3_q_s3", 8'(q), 8'hF);
        check("t3_wrap_s3", 8'(wrapped), 8'h1);
`else
        check("t3_q_s3", 8'(q), 8'h1);
        check("t3_wrap_s3", 8'(wrapped), 8'h0);
`endif
        check("t3_done", 8'(done), 8'h1);
        tick();
        check("t3_idle", 8'(busy), 8'h0);

        // 4: CLEAR then COUNT_DN len=2
        send(2'b00, 4'h7, 8'd0);
        tick();
        cmd_valid = 1'b0;
`ifdef TFF_SATURATE_EN
        check("t4_tvec_clear", 8'(t_vec), 8'hF);
`else
        check("t4_tvec_clear", 8'(t_vec), 8'h1);
`endif
        tick();
        check("t4_q_clear", 8'(q), 8'h0);
        check("t4_done_clear", 8'(done), 8'h1);
        tick();
        send(2'b11, 4'h0, 8'd2);
        tick();
        cmd_valid = 1'b0;
`ifdef TFF_SATURATE_EN
        check("t4_tvec_dn0", 8'(t_vec), 8'h0);
`else
        check("t4_tvec_dn0", 8'(t_vec), 8'hF);
`endif
        tick();
`ifdef TFF_SATURATE_EN
        check("t4_q_s1", 8'(q), 8'h0);
`else
        check("t4_q_s1", 8'(q), 8'hF);
`endif
        check("t4_wrap_s1", 8'(wrapped), 8'h1);
        tick();
`ifdef TFF_SATURATE_EN
        check("t4_q_s2", 8'(q), 8'h0);
        check("t4_wrap_s2", 8'(wrapped), 8'h1);
`else
        check("t4_q_s2", 8'(q), 8'hE);
        check("t4_wrap_s2", 8'(wrapped), 8'h0);
`endif
        check("t4_done", 8'(done), 8'h1);
        tick();

        // 5: known start value, then COUNT_UP len=0 with cmd_valid held
        send(2'b01, 4'hE, 8'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        send(2'b10, 4'h0, 8'd0);
        tick();
        check("t5_done_len0", 8'(done), 8'h1);
        check("t5_q_len0", 8'(q), 8'hE);
        check("t5_ready_busy", 8'(cmd_ready), 8'h0);
        tick();
        check("t5_idle", 8'(busy), 8'h0);
        check("t5_done_off", 8'(done), 8'h0);
        cmd_valid = 1'b0;
        tick();
        check("t5_still_idle", 8'(busy), 8'h0);
        check("t5_q_hold", 8'(q), 8'hE);

        // 5b: COUNT_DN len=2 with cmd_valid held throughout, only one command taken
        send(2'b11, 4'h0, 8'd2);
        tick();
        check("t5b_q_s0", 8'(q), 8'hE);
        tick();
        check("t5b_q_s1", 8'(q), 8'hD);
        tick();
        check("t5b_q_s2", 8'(q), 8'hC);
        check("t5b_done", 8'(done), 8'h1);
        cmd_valid = 1'b0;
        tick();
        check("t5b_idle", 8'(busy), 8'h0);
        tick();
        check("t5b_no_second", 8'(busy), 8'h0);
        check("t5b_q_final", 8'(q), 8'hC);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
